// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a small valid/ready input FIFO.
// Define UART_TX_BREAK_EN to add the i_break input that holds the idle line low.
module uart_tx_param #(
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned STOP_TICKS  = 16,
   parameter int unsigned PARITY_MODE = 0,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_bd_tick,
   input  logic [DATA_BITS-1:0]        i_data,
   input  logic                        i_valid,
`ifdef UART_TX_BREAK_EN
   input  logic                        i_break,
`endif
   output logic                        o_ready,
   output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
   output logic                        o_busy,
   output logic                        o_tx
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam bit HAS_PARITY = (PARITY_MODE == 1) || (PARITY_MODE == 2);
   localparam bit ODD_PARITY = (PARITY_MODE == 2);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state_q, state_d;
   logic [5:0]           tick_q, tick_d;
   logic [4:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;

   logic                 push_c, pop_c, brk_c, tick_last_c;
   logic [5:0]           limit_c;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]     count_q;

`ifdef UART_TX_BREAK_EN
   assign brk_c = i_break;
`else
   assign brk_c = 1'b0;
`endif

   assign o_ready      = (count_q != CNT_W'(FIFO_DEPTH));
   assign o_fifo_count = count_q;
   assign o_busy       = (state_q != IDLE);
   assign o_tx         = tx_q;
   assign push_c       = i_valid && o_ready;

   // Bit boundary is the tick that completes the current state's count
   assign limit_c     = (state_q == STOP) ? 6'(STOP_TICKS - 1) : 6'(OVERSAMPLE - 1);
   assign tick_last_c = i_bd_tick && (tick_q == limit_c);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
      end
   end

   // Next state; the line level follows the current state one cycle later
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      pop_c   = 1'b0;
      tx_d    = 1'b1;

      if (state_q != IDLE && i_bd_tick) begin
         tick_d = tick_last_c ? 6'd0 : tick_q + 6'd1;
      end

      case (state_q)
         IDLE: begin
            tx_d = ~brk_c;
            if (!brk_c && count_q != '0) begin
               pop_c   = 1'b1;
               shift_d = mem[rd_ptr_q];
               tick_d  = 6'd0;
               par_d   = 1'b0;
               state_d = START;
            end
         end
         START: begin
            tx_d = 1'b0;
            if (tick_last_c) begin
               bit_d   = 5'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            tx_d = shift_q[0];
            if (tick_last_c) begin
               shift_d = shift_q >> 1;
               par_d   = par_q ^ shift_q[0];
               bit_d   = bit_q + 5'd1;
               if (bit_q == 5'(DATA_BITS - 1)) begin
                  state_d = HAS_PARITY ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            tx_d = par_q ^ ODD_PARITY;
            if (tick_last_c) begin
               state_d = STOP;
            end
         end
         STOP: begin
            tx_d = 1'b1;
            // Back-to-back: a queued word starts without an idle bit time
            if (tick_last_c) begin
               if (!brk_c && count_q != '0) begin
                  pop_c   = 1'b1;
                  shift_d = mem[rd_ptr_q];
                  par_d   = 1'b0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO pointers and occupancy
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_c, pop_c})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (push_c) mem[wr_ptr_q] <= i_data;
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: scoreboard bench; three configurations, line monitors compare whole frames.
module tb_uart_tx_param;

   typedef struct packed {
      logic [31:0] data;
      logic        par;
      logic        busy_end;
      logic        b2b;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0 = 1'b1;
   logic       rst12 = 1'b1;
   logic [1:0] div = 2'd0;
   logic       tick3;
   int         cyc = 0;
   logic [2:0] mon_on = 3'b111;
   int         n_cmp = 0;
   int         n_err = 0;

   assign tick3 = (div == 2'd0);
   always @(posedge clk) div <= (div == 2'd2) ? 2'd0 : div + 2'd1;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] data0 = '0;
   logic [7:0] data1 = '0;
   logic [4:0] data2 = '0;
   logic       valid0 = 1'b0, valid1 = 1'b0, valid2 = 1'b0;
   logic       ready0, ready1, ready2, busy0, busy1, busy2, tx0, tx1, tx2;
   logic [2:0] cnt0;
   logic [3:0] cnt1;
   logic [1:0] cnt2;
`ifdef UART_TX_BREAK_EN
   logic       brk0 = 1'b0;
   logic       brk_off = 1'b0;
`endif

   uart_tx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_TICKS(16), .PARITY_MODE(0), .FIFO_DEPTH(4)) u0 (
      .i_clk(clk), .i_reset(rst0), .i_bd_tick(1'b1), .i_data(data0), .i_valid(valid0),
`ifdef UART_TX_BREAK_EN
      .i_break(brk0),
`endif
      .o_ready(ready0), .o_fifo_count(cnt0), .o_busy(busy0), .o_tx(tx0));

   uart_tx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_TICKS(16), .PARITY_MODE(1), .FIFO_DEPTH(8)) u1 (
      .i_clk(clk), .i_reset(rst12), .i_bd_tick(1'b1), .i_data(data1), .i_valid(valid1),
`ifdef UART_TX_BREAK_EN
      .i_break(brk_off),
`endif
      .o_ready(ready1), .o_fifo_count(cnt1), .o_busy(busy1), .o_tx(tx1));

   uart_tx_param #(.DATA_BITS(5), .OVERSAMPLE(16), .STOP_TICKS(32), .PARITY_MODE(2), .FIFO_DEPTH(2)) u2 (
      .i_clk(clk), .i_reset(rst12), .i_bd_tick(tick3), .i_data(data2), .i_valid(valid2),
`ifdef UART_TX_BREAK_EN
      .i_break(brk_off),
`endif
      .o_ready(ready2), .o_fifo_count(cnt2), .o_busy(busy2), .o_tx(tx2));

   exp_t q0[$], q1[$], q2[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] d, input logic p, input logic be, input logic bb);
      exp_t e;
      e.data = d; e.par = p; e.busy_end = be; e.b2b = bb;
      return e;
   endfunction

   function automatic logic get_tx(input int k);
      case (k)
         0:       return tx0;
         1:       return tx1;
         default: return tx2;
      endcase
   endfunction

   function automatic logic get_busy(input int k);
      case (k)
         0:       return busy0;
         1:       return busy1;
         default: return busy2;
      endcase
   endfunction

   // Per-configuration frame geometry in clock cycles
   function automatic int bp_of(input int k); return (k == 2) ? 48 : 16; endfunction
   function automatic int db_of(input int k); return (k == 2) ? 5 : 8;   endfunction
   function automatic int pb_of(input int k); return (k == 0) ? 0 : 1;   endfunction
   function automatic int sp_of(input int k); return (k == 2) ? 96 : 16; endfunction

   function automatic int q_size(input int k);
      case (k)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic exp_push(input int k, input exp_t e);
      case (k)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic q_pop(input int k, output exp_t e);
      case (k)
         0:       e = q0.pop_front();
         1:       e = q1.pop_front();
         default: e = q2.pop_front();
      endcase
   endtask

   task automatic push(input int k, input logic [31:0] d);
      @(negedge clk);
      if (k == 2) while (div != 2'd2) @(negedge clk);
      case (k)
         0:       begin data0 = d[7:0]; valid0 = 1'b1; end
         1:       begin data1 = d[7:0]; valid1 = 1'b1; end
         default: begin data2 = d[4:0]; valid2 = 1'b1; end
      endcase
      @(posedge clk);
      #1;
      valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
   endtask

   // Line monitor: on each start edge pop the expected word and check every cycle of the frame
   task automatic mon(input int k);
      exp_t e;
      logic prev, lv, ex, bad, bad_v, bad_e, busy_last, busy_first;
      int   bp, db, nb, n, bi, bad_j, start_c, last_end;
      prev = 1'b1;
      last_end = -1000;
      forever begin
         @(negedge clk);
         lv = get_tx(k);
         if (prev === 1'b1 && lv === 1'b0 && mon_on[k]) begin
            start_c = cyc;
            if (q_size(k) == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_frame%0d: start at cycle %0d, required no frame", k, start_c);
            end else begin
               q_pop(k, e);
               bp = bp_of(k); db = db_of(k);
               nb = 1 + db + pb_of(k);
               n  = bp * nb + sp_of(k);
               bad = 1'b0; bad_j = 0; bad_v = 1'b0; bad_e = 1'b0;
               busy_first = get_busy(k); busy_last = 1'b0;
               for (int j = 0; j < n; j++) begin
                  if (j > 0) begin @(negedge clk); lv = get_tx(k); end
                  if (!mon_on[k]) break;
                  bi = j / bp;
                  if (bi == 0)                          ex = 1'b0;
                  else if (bi <= db)                    ex = e.data[bi-1];
                  else if (bi == db + 1 && pb_of(k) != 0) ex = e.par;
                  else                                  ex = 1'b1;
                  if (lv !== ex && !bad) begin bad = 1'b1; bad_j = j; bad_v = lv; bad_e = ex; end
                  if (j == n - 1) busy_last = get_busy(k);
               end
               if (mon_on[k]) begin
                  n_cmp++;
                  if (bad) begin
                     n_err++;
                     $display("FAIL frame%0d word 0x%0h: cycle %0d of frame got line %b, required %b",
                              k, e.data, bad_j, bad_v, bad_e);
                  end
                  chk($sformatf("busy_start%0d", k), 32'(busy_first), 32'd1);
                  chk($sformatf("busy_end%0d", k), 32'(busy_last), 32'(e.busy_end));
                  if (e.b2b) chk($sformatf("b2b_gap%0d", k), 32'(start_c - last_end), 32'd1);
                  last_end = cyc;
               end
            end
         end
         prev = lv;
      end
   endtask

   task automatic wait_idle(input int k, input int budget);
      int n = 0;
      while ((q_size(k) != 0 || get_busy(k) !== 1'b0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("drain%0d", k), 32'(n < budget), 32'd1);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      fork
         mon(0);
         mon(1);
         mon(2);
      join_none
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      logic [7:0] w [6];
      logic       r;
      int         idx;
      w[0] = 8'h3C; w[1] = 8'h81; w[2] = 8'h42; w[3] = 8'hFF; w[4] = 8'h00; w[5] = 8'h99;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst0 = 1'b0; rst12 = 1'b0;
      @(negedge clk);
      chk("reset_tx",    32'(tx0),    32'd1);
      chk("reset_busy",  32'(busy0),  32'd0);
      chk("reset_ready", 32'(ready0), 32'd1);
      chk("reset_count", 32'(cnt0),   32'd0);

      // 0xA5 on the 8N1 config: line 0,1,0,1,0,0,1,0,1,1 with 2-cycle push-to-start latency
      exp_push(0, mk(32'hA5, 1'b0, 1'b0, 1'b0));
      push(0, 32'hA5);
      @(negedge clk);
      chk("lat_count_queued", 32'(cnt0), 32'd1);
      chk("lat_tx_c0",        32'(tx0),  32'd1);
      @(negedge clk);
      chk("lat_tx_c1",        32'(tx0),  32'd1);
      chk("lat_busy_c1",      32'(busy0), 32'd1);
      chk("lat_count_popped", 32'(cnt0), 32'd0);
      @(negedge clk);
      chk("lat_tx_c2",        32'(tx0),  32'd0);
      wait_idle(0, 400);
      chk("a5_count_zero", 32'(cnt0), 32'd0);

      // Parity: even config 0x07 -> 1; odd 5-bit config, tick every 3rd cycle: 0x1F -> 0, 0x03 -> 1
      exp_push(1, mk(32'h07, 1'b1, 1'b0, 1'b0));
      push(1, 32'h07);
      exp_push(2, mk(32'h1F, 1'b0, 1'b1, 1'b0));
      push(2, 32'h1F);
      exp_push(2, mk(32'h03, 1'b1, 1'b0, 1'b1));
      push(2, 32'h03);
      wait_idle(1, 400);
      wait_idle(2, 2000);
      chk("u1_count", 32'(cnt1),   32'd0);
      chk("u1_ready", 32'(ready1), 32'd1);
      chk("u2_count", 32'(cnt2),   32'd0);
      chk("u2_ready", 32'(ready2), 32'd1);

      // FIFO fill: 6 words offered, 1 in flight + 4 queued accepted, frames back-to-back
      exp_push(0, mk(32'(w[0]), 1'b0, 1'b1, 1'b0));
      exp_push(0, mk(32'(w[1]), 1'b0, 1'b1, 1'b1));
      exp_push(0, mk(32'(w[2]), 1'b0, 1'b1, 1'b1));
      exp_push(0, mk(32'(w[3]), 1'b0, 1'b1, 1'b1));
      exp_push(0, mk(32'(w[4]), 1'b0, 1'b0, 1'b1));
      push(0, 32'(w[0]));
      data0 = w[1]; valid0 = 1'b1; idx = 1;
      repeat (30) begin
         @(negedge clk);
         r = ready0;
         @(posedge clk);
         #1;
         if (r && idx < 6) begin
            idx++;
            if (idx < 6) data0 = w[idx];
         end
      end
      valid0 = 1'b0;
      @(negedge clk);
      chk("full_count",    32'(cnt0),   32'd4);
      chk("full_ready",    32'(ready0), 32'd0);
      chk("full_accepted", 32'(idx),    32'd5);
      wait_idle(0, 1200);
      chk("full_drained", 32'(cnt0), 32'd0);

`ifdef UART_TX_BREAK_EN
      // Break holds the idle line low and blocks the pop; start follows one cycle after release
      @(posedge clk);
      mon_on[0] = 1'b0;
      @(negedge clk);
      brk0 = 1'b1;
      push(0, 32'hC3);
      repeat (5) @(negedge clk);
      chk("brk_tx",    32'(tx0),   32'd0);
      chk("brk_busy",  32'(busy0), 32'd0);
      chk("brk_count", 32'(cnt0),  32'd1);
      brk0 = 1'b0;
      exp_push(0, mk(32'hC3, 1'b0, 1'b0, 1'b0));
      @(posedge clk);
      mon_on[0] = 1'b1;
      @(negedge clk);
      chk("brk_rel_tx",   32'(tx0),   32'd1);
      chk("brk_rel_busy", 32'(busy0), 32'd1);
      @(negedge clk);
      chk("brk_rel_start", 32'(tx0), 32'd0);
      wait_idle(0, 400);
`endif

      // Reset mid-DATA with two words queued: line high, FIFO flushed, nothing else sent
      @(posedge clk);
      mon_on[0] = 1'b0;
      push(0, 32'h11);
      push(0, 32'h22);
      push(0, 32'h33);
      repeat (55) @(negedge clk);
      chk("pre_reset_count", 32'(cnt0),  32'd2);
      chk("pre_reset_busy",  32'(busy0), 32'd1);
      rst0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid_reset_tx",    32'(tx0),    32'd1);
      chk("mid_reset_busy",  32'(busy0),  32'd0);
      chk("mid_reset_count", 32'(cnt0),   32'd0);
      chk("mid_reset_ready", 32'(ready0), 32'd1);
      rst0 = 1'b0;
      repeat (40) @(negedge clk);
      chk("post_reset_tx",   32'(tx0),   32'd1);
      chk("post_reset_busy", 32'(busy0), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
